// File: rtl/garage_mem_pkg.sv
// Shared types and constants for the data-RAM port B arbiter.
//   portb_state_t : port B controller state (clear sweep, then serving requesters)
//   REQ_LOADER    : requester index of the host loader/debug port
//   REQ_DISPLAY   : requester index of the display scanner port
package garage_mem_pkg;

  typedef enum logic {ST_CLEAR, ST_SERVE} portb_state_t;

  localparam int unsigned REQ_LOADER  = 0;
  localparam int unsigned REQ_DISPLAY = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with same-cycle (combinational) grant.
// Ports:
//   clk    : clock
//   resetN : synchronous active-low reset
//   en     : grants allowed; low forces gnt to zero and freezes rr_last
//   req    : request vector, bit i from requester i
//   gnt    : grant vector, one-hot or zero
module rr_arbiter2
  import garage_mem_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the most recently granted requester; resets to the display so the
  // loader wins the first contended cycle.
  logic rr_last;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[REQ_LOADER] && (!req[REQ_DISPLAY] || rr_last)) begin
        gnt[REQ_LOADER] = 1'b1;
      end else if (req[REQ_DISPLAY]) begin
        gnt[REQ_DISPLAY] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      rr_last <= 1'b1;
    end else if (gnt[REQ_LOADER]) begin
      rr_last <= 1'b0;
    end else if (gnt[REQ_DISPLAY]) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_b_arbiter.sv
// Owner of port B of the dual-port data RAM. After reset it optionally zeroes
// the whole RAM, then shares port B round-robin between the host loader
// (read/write) and the display scanner (read only).
// Ports:
//   clk, resetN                   : clock, synchronous active-low reset
//   req0/we0/addr0/wdata0, gnt0   : loader request (held until gnt0) and grant
//   req1/addr1, gnt1              : display read request (held until gnt1) and grant
//   rdata, rvalid0, rvalid1       : shared read data, tagged per requester, 1 cycle after grant
//   clear_busy                    : high while the clear sweep runs
//   ram_address_b/data_b/wren_b   : to RAM port B
//   ram_q_b                       : from RAM port B, registered read
module ram_port_b_arbiter
  import garage_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 16,
  parameter int unsigned RAM_REGISTER_COUNT = 1024,
  parameter int unsigned CLEAR_ON_RESET     = 1,
  localparam int unsigned ADDR_WIDTH        = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_wren_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST    = ADDR_WIDTH'(RAM_REGISTER_COUNT - 1);
  localparam portb_state_t          RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_SERVE;

  portb_state_t          state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [1:0]            gnt;
  logic                  arb_en;

  // Gating with resetN keeps grants and writes off during the reset cycle itself.
  assign arb_en     = resetN && (state == ST_SERVE);
  assign clear_busy = resetN && (state == ST_CLEAR);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetN (resetN),
    .en     (arb_en),
    .req    ({req1, req0}),
    .gnt    (gnt)
  );

  assign gnt0  = gnt[REQ_LOADER];
  assign gnt1  = gnt[REQ_DISPLAY];
  assign rdata = ram_q_b;

  // Port B mux; the address holds its last driven value when idle.
  always_comb begin
    ram_address_b = addr_hold;
    ram_data_b    = '0;
    ram_wren_b    = 1'b0;
    if (clear_busy) begin
      ram_address_b = clr_cnt;
      ram_wren_b    = 1'b1;
    end else if (gnt0) begin
      ram_address_b = addr0;
      ram_data_b    = wdata0;
      ram_wren_b    = we0;
    end else if (gnt1) begin
      ram_address_b = addr1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= RESET_STATE;
      clr_cnt   <= '0;
      addr_hold <= '0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
    end else begin
      addr_hold <= ram_address_b;
      rvalid0   <= gnt0 && !we0;
      rvalid1   <= gnt1;
      unique case (state)
        ST_CLEAR: begin
          // Last address is written this cycle; counter stops rather than wraps.
          if (clr_cnt == CLR_LAST) begin
            state <= ST_SERVE;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_SERVE: state <= ST_SERVE;
        default:  state <= RESET_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_b_arbiter.sv
module tb_ram_port_b_arbiter;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 16-word RAM with clear sweep
  logic          resetN = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, clear_busy, ram_wren_b;
  logic [DW-1:0] rdata, ram_data_b, ram_q_b;
  logic [AW-1:0] ram_address_b;

  // Instance B: no clear sweep, constant RAM read data
  logic          rst2N = 1'b0;
  logic          b_req0 = 1'b0, b_we0 = 1'b0, b_req1 = 1'b0;
  logic [AW-1:0] b_addr0 = '0, b_addr1 = '0;
  logic [DW-1:0] b_wdata0 = '0;
  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_clear_busy, b_ram_wren_b;
  logic [DW-1:0] b_rdata, b_ram_data_b;
  logic [DW-1:0] b_ram_q_b = 16'h00a5;
  logic [AW-1:0] b_ram_address_b;
  logic          b_busy_seen = 1'b0;

  ram_port_b_arbiter #(.DATA_WIDTH(DW), .RAM_REGISTER_COUNT(N), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .resetN(resetN),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1), .clear_busy(clear_busy),
    .ram_address_b(ram_address_b), .ram_data_b(ram_data_b), .ram_wren_b(ram_wren_b),
    .ram_q_b(ram_q_b)
  );

  ram_port_b_arbiter #(.DATA_WIDTH(DW), .RAM_REGISTER_COUNT(N), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .resetN(rst2N),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .gnt0(b_gnt0),
    .req1(b_req1), .addr1(b_addr1), .gnt1(b_gnt1),
    .rdata(b_rdata), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1), .clear_busy(b_clear_busy),
    .ram_address_b(b_ram_address_b), .ram_data_b(b_ram_data_b), .ram_wren_b(b_ram_wren_b),
    .ram_q_b(b_ram_q_b)
  );

  // RAM behind instance A: registered read, starts with junk so the sweep matters
  logic [DW-1:0] ram_mem [N];
  initial for (int i = 0; i < N; i++) ram_mem[i] = 16'hdead;
  always @(posedge clk) begin
    if (ram_wren_b) ram_mem[ram_address_b] <= ram_data_b;
    ram_q_b <= ram_mem[ram_address_b];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected RAM contents and pending reads
  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
  } rd_t;
  rd_t           sb[$];
  logic [DW-1:0] exp_mem [N];
  initial for (int i = 0; i < N; i++) exp_mem[i] = '0;

  always @(negedge clk) begin
    if (!resetN) begin
      sb.delete();
    end else begin
      if (rvalid0 || rvalid1) begin
        if (sb.size() == 0) begin
          check_eq("rvalid_unexpected", {rvalid1, rvalid0}, 2'b00);
        end else begin
          rd_t e;
          e = sb.pop_front();
          check_eq("rvalid_tag", {rvalid1, rvalid0}, e.id ? 2'b10 : 2'b01);
          check_eq("rdata", rdata, e.data);
        end
      end
      if (gnt0) begin
        if (we0) exp_mem[addr0] = wdata0;
        else sb.push_back(rd_t'{id: 1'b0, data: exp_mem[addr0]});
      end
      if (gnt1) sb.push_back(rd_t'{id: 1'b1, data: exp_mem[addr1]});
    end
  end

  always @(negedge clk) if (b_clear_busy) b_busy_seen = 1'b1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    resetN = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_eq("rst_wren", ram_wren_b, 1'b0);
      check_eq("rst_busy", clear_busy, 1'b0);
      check_eq("rst_gnt", {gnt1, gnt0}, 2'b00);
      step();
    end
    resetN = 1'b1;
  endtask

  task automatic check_sweep(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check_eq({tag, "_busy"}, clear_busy, 1'b1);
      check_eq({tag, "_wren"}, ram_wren_b, 1'b1);
      check_eq({tag, "_addr"}, ram_address_b, k);
      check_eq({tag, "_data"}, ram_data_b, 0);
      check_eq({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
      check_eq({tag, "_rvalid"}, {rvalid1, rvalid0}, 2'b00);
      step();
    end
  endtask

  // Loader transfer held until granted (bounded), then released
  task automatic xfer0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input string tag);
    int i;
    req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    i = 0;
    @(negedge clk);
    while (!gnt0 && i < 20) begin
      step();
      @(negedge clk);
      i++;
    end
    check_eq({tag, "_gnt0"}, gnt0, 1'b1);
    check_eq({tag, "_wren"}, ram_wren_b, we);
    check_eq({tag, "_addr"}, ram_address_b, a);
    if (we) check_eq({tag, "_wdata"}, ram_data_b, d);
    step();
    req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset, full sweep, loader held through sweep gets granted right after
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    do_reset(3);
    check_sweep(N, "t1");
    @(negedge clk);
    check_eq("t1_busy_done", clear_busy, 1'b0);
    check_eq("t1_gnt0_after_sweep", gnt0, 1'b1);
    step();
    req0 = 1'b0;
    step();

    // 2: write then display read of same address
    xfer0(1'b1, 4'd5, 16'h1234, "t2w");
    req1 = 1'b1; addr1 = 4'd5;
    @(negedge clk);
    check_eq("t2_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    @(negedge clk);
    check_eq("t2_rvalid1", rvalid1, 1'b1);
    check_eq("t2_rdata", rdata, 16'h1234);
    step();

    // 3: contention alternates
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd5;
    req1 = 1'b1; addr1 = 4'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq($sformatf("t3_gnt_%0d", i), {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // 4: back-to-back loader reads
    xfer0(1'b1, 4'd7, 16'h0707, "t4w7");
    xfer0(1'b1, 4'd8, 16'h0808, "t4w8");
    xfer0(1'b1, 4'd12, 16'hbeef, "t4w12");
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
    @(negedge clk);
    check_eq("t4_gnt_a", gnt0, 1'b1);
    step();
    addr0 = 4'd8;
    @(negedge clk);
    check_eq("t4_gnt_b", gnt0, 1'b1);
    check_eq("t4_rvalid_a", rvalid0, 1'b1);
    check_eq("t4_rdata_a", rdata, 16'h0707);
    step();
    req0 = 1'b0;
    @(negedge clk);
    check_eq("t4_rvalid_b", rvalid0, 1'b1);
    check_eq("t4_rdata_b", rdata, 16'h0808);
    step();
    @(negedge clk);
    check_eq("t4_rvalid_off", rvalid0, 1'b0);
    step();

    // 5: reset with a read in flight, then reset again mid-sweep
    req1 = 1'b1; addr1 = 4'd7;
    @(negedge clk);
    check_eq("t5_gnt1", gnt1, 1'b1);
    step();
    req1 = 1'b0;
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    do_reset(2);
    check_sweep(9, "t5a");
    do_reset(2);
    check_sweep(N, "t5b");
    @(negedge clk);
    check_eq("t5_busy_done", clear_busy, 1'b0);
    step();
    xfer0(1'b0, 4'd12, 16'h0000, "t5r");
    step();
    step();

    // 6: no-clear variant grants on first cycle after reset
    b_req1 = 1'b1; b_addr1 = 4'd3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("t6_rst_gnt1", b_gnt1, 1'b0);
      step();
    end
    rst2N = 1'b1;
    @(negedge clk);
    check_eq("t6_gnt1", b_gnt1, 1'b1);
    check_eq("t6_busy", b_clear_busy, 1'b0);
    check_eq("t6_addr", b_ram_address_b, 4'd3);
    check_eq("t6_wren", b_ram_wren_b, 1'b0);
    step();
    b_req1 = 1'b0;
    @(negedge clk);
    check_eq("t6_rvalid1", b_rvalid1, 1'b1);
    check_eq("t6_rdata", b_rdata, 16'h00a5);
    step();
    check_eq("t6_busy_never", b_busy_seen, 1'b0);
    check_eq("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
